// File: rtl/trash_pkg.sv
// Shared constants and types for the trash CPU core and its host-side loader.
package trash_pkg;

  localparam int unsigned BUS_W  = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BUS_W-1:0] NOOP_WORD = 16'h0001;

  // Bus bit 0 selects program-write versus execute.
  localparam logic MODE_PROG = 1'b0;
  localparam logic MODE_EXEC = 1'b1;

  // Core opcodes, carried in bus bits [3:1].
  localparam logic [2:0] OP_NOOP  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_JZ    = 3'd6;
  localparam logic [2:0] OP_OUT   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_TRST = 2'd2,
    ST_LOAD = 2'd3
  } loader_state_e;

endpackage

// File: rtl/trash_prog_loader.sv
// Host byte stream to trash core instruction bus: execute forwarder and
// buffered program-image burst loader. Bus idles at an execute NOOP.
module trash_prog_loader
  import trash_pkg::*;
#(
  parameter int unsigned PROG_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BYTE_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 load_req,
  output logic [BUS_W-1:0]     bus,
  output logic                 tgt_rst_n,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned      IDX_W    = $clog2(PROG_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PROG_BYTES - 1);

  loader_state_e     state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_inc;
  logic              half_q;
  logic [6:0]        lo_q;
  logic [BYTE_W-1:0] mem_q [PROG_BYTES];
  logic [BUS_W-1:0]  bus_q;
  logic              tgt_rst_n_q;
  logic              busy_q;
  logic              done_q;
  logic              hs;

  // Ready is decoded from state; load_req steals the IDLE cycle it arrives in.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: s_ready = ~load_req;
      ST_FILL: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign hs      = s_valid & s_ready;
  assign idx_inc = idx_q + 1'b1;

  // FSM; outputs are registered from the state being entered so they line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      half_q      <= 1'b0;
      lo_q        <= '0;
      bus_q       <= NOOP_WORD;
      tgt_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bus_q       <= NOOP_WORD;
      tgt_rst_n_q <= 1'b1;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (load_req) begin
            state_q <= ST_FILL;
            half_q  <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end else if (hs) begin
            if (!half_q) begin
              lo_q   <= s_data[7:1];
              half_q <= 1'b1;
            end else begin
              bus_q  <= {s_data, lo_q, MODE_EXEC};
              half_q <= 1'b0;
            end
          end
        end
        ST_FILL: begin
          if (hs) begin
            mem_q[idx_q] <= s_data;
            idx_q        <= idx_inc;
            if (idx_q == IDX_LAST) begin
              state_q     <= ST_TRST;
              tgt_rst_n_q <= 1'b0;
            end
          end
        end
        ST_TRST: begin
          // Core PC is zero on leaving reset; word 0 goes out next.
          state_q <= ST_LOAD;
          idx_q   <= '0;
          bus_q   <= {mem_q[0], 7'h00, MODE_PROG};
          done_q  <= (IDX_LAST == '0);
        end
        ST_LOAD: begin
          idx_q <= idx_inc;
          if (idx_q == IDX_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            bus_q  <= {mem_q[idx_inc], 7'h00, MODE_PROG};
            done_q <= (idx_inc == IDX_LAST);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus       = bus_q;
  assign tgt_rst_n = tgt_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
